div_seq: RTL and testbench
==========================

# div_seq

Sequential unsigned 32-bit divider: one restoring subtract step per clock, with an optional 16.16 fixed-point offset mode. It is the inverse-direction companion to the team's combinational adder cells. It sits beside the GPU/DSP ALU as the multi-cycle DIV resource. It accepts an operand pair on a start strobe, iterates, and presents the quotient, remainder and status flags with a one-cycle done pulse.

## Interface
- No parameters; widths are fixed at 32 bits.
- sys_clk  in  1  system clock; all state changes on its rising edge
- resetl  in  1  asynchronous, active-low reset
- start  in  1  request a divide; sampled on each rising edge
- offset  in  1  sampled with start; 1 = dividend is treated as dividend<<16 (48-bit numerator)
- dividend  in  32  numerator, sampled with start
- divisor  in  32  denominator, sampled with start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when results are valid
- quotient  out  32  low 32 bits of the quotient; held until the next accepted start
- remainder  out  32  final remainder; held likewise
- dz  out  1  divide-by-zero flag for the last operation
- ovf  out  1  offset mode only: quotient bits 47:32 were nonzero

## Operation
- States: IDLE, RUN, DONE.
- A start is accepted in IDLE or DONE. It is ignored in RUN: operands are not re-latched and no restart occurs.
- On accept:
  - Latch divisor and the numerator: {16'h0, dividend} normally, {dividend, 16'h0} if offset.
  - Set N = 32 (offset=0) or 48 (offset=1).
  - Clear the 33-bit partial remainder P, the quotient shift register, dz and ovf.
- Divisor zero on accept:
  - Go directly to DONE.
  - quotient=32'hFFFF_FFFF, remainder=dividend, dz=1, ovf=0.
  - No RUN cycles are executed.
- RUN iteration, MSB-first over the N numerator bits:
  - P' = {P[31:0], next numerator bit}.
  - Trial difference D = P' + ~{1'b0,divisor} + 1, computed 34 bits wide. Carry out = 1 means no borrow.
  - On carry: P = D[32:0] and the quotient bit is 1. Otherwise P = P' and the quotient bit is 0.
  - Quotient bits shift in at the LSB. The shift register is 48 bits wide. Any 1 shifted out of bit 31 sets the ovf sticky.
- After N iterations, go to DONE:
  - quotient = shift register [31:0].
  - remainder = P[31:0]. P[32] is always 0 at this point.
- DONE lasts one cycle, then returns to IDLE unless start is accepted in DONE.
- Arithmetic is unsigned only. Signed handling is the caller's job.

## Timing
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, dz=0, ovf=0, quotient=0, remainder=0.
- Let start be high at rising edge E0 with a nonzero divisor:
  - busy=1 after E0 through edge E0+N−1, i.e. exactly N cycles.
  - After edge E0+N: busy=0, done=1 for exactly one cycle, and quotient/remainder/dz/ovf are valid.
  - Latency is therefore 33 cycles normally and 49 in offset mode, from the start edge to the first edge at which done=1 is sampled.
- Divide-by-zero: done=1 after E0, busy stays 0, and latency is 1 cycle.
- busy and done are never high together.
- Outputs change only at the DONE transition. They are stable during RUN and IDLE.
- Start held continuously: re-accepted on each DONE cycle, giving back-to-back operations every N+1 cycles.
- resetl low mid-RUN aborts immediately to the reset values. No done pulse is issued.
- Operand inputs may change freely after the accept edge.

## Test plan
- 100 / 7, offset=0 → done at E0+33: quotient=14, remainder=2, dz=0, ovf=0. busy high for exactly 32 cycles.
- offset=1, 1 / 2 → done at E0+49: quotient=32'h0000_8000, remainder=0, ovf=0. Then offset=1, 32'h0001_0000 / 1 → quotient=0, ovf=1.
- Divisor 0, dividend 32'h1234_5678 → done one cycle after start: quotient=32'hFFFF_FFFF, remainder=32'h1234_5678, dz=1, busy never high.
- 32'hFFFF_FFFF / 1 → quotient=32'hFFFF_FFFF, remainder=0. Then 5 / 32'hFFFF_FFFF → quotient=0, remainder=5.
- Issue 100/7, then pulse start with 50/5 at E0+10 → results still 14 r2 at E0+33. Start held high through DONE with 50/5 → second done 33 cycles later: quotient=10, remainder=0.
- Drop resetl at E0+15 of a divide → all outputs at reset values, no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/div_seq_if.sv
// Operand/result bundle for the sequential divider. The requester uses the
// master modport and the divider uses the slave modport.
interface div_seq_if;
  logic        start;
  logic        offset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dz;
  logic        ovf;

  modport master (
    output start, offset, dividend, divisor,
    input  busy, done, quotient, remainder, dz, ovf
  );

  modport slave (
    input  start, offset, dividend, divisor,
    output busy, done, quotient, remainder, dz, ovf
  );
endinterface

// File: rtl/div_seq.sv
// Sequential unsigned 32-bit restoring divider with an optional 16.16 offset
// mode. It performs one subtract step per clock and pulses done for one cycle.
module div_seq (
  input  logic      sys_clk,
  input  logic      resetl,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [47:0] num_q, num_d;
  logic [31:0] qsr_q, qsr_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovf_run_q, ovf_run_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  logic [32:0] p_shift;
  logic [31:0] trial;
  logic        trial_msb_unused;
  logic        carry;
  logic        accept;

  // The invariant P < divisor holds between steps. This keeps P'-d below 2^32,
  // so bit 32 of the trial difference and of P is always zero and is not stored.
  always_comb begin
    p_shift = {p_q, num_q[47]};
    {carry, trial_msb_unused, trial} = {1'b0, p_shift} + {1'b0, ~{1'b0, dvs_q}} + 34'd1;
  end

  assign accept = bus.start && (state_q != S_RUN);

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    num_d     = num_q;
    qsr_d     = qsr_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    ovf_run_d = ovf_run_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // Both modes consume the numerator MSB-first from {dividend, 16'h0}.
          // Normal mode stops after 32 bits and offset mode runs through the low zeros.
          num_d     = {bus.dividend, 16'h0};
          dvs_d     = bus.divisor;
          cnt_d     = bus.offset ? 6'd48 : 6'd32;
          p_d       = '0;
          qsr_d     = '0;
          ovf_run_d = 1'b0;
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        p_d       = carry ? trial : p_shift[31:0];
        qsr_d     = {qsr_q[30:0], carry};
        num_d     = {num_q[46:0], 1'b0};
        ovf_run_d = ovf_run_q | qsr_q[31];
        cnt_d     = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = S_DONE;
          quo_d   = qsr_d;
          rem_d   = p_d;
          dz_d    = 1'b0;
          ovf_d   = ovf_run_d;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      num_q     <= '0;
      qsr_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      num_q     <= num_d;
      qsr_q     <= qsr_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      ovf_run_q <= ovf_run_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed operands with hand-computed results
// are queued at issue, and a monitor checks each done pulse against the queue.
module tb_div_seq;

  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;

  div_seq_if bus();

  div_seq dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: done=1 is observed after edge E0+lat at the following falling edge.
  always @(negedge sys_clk) begin
    if (bus.done) begin
      exp_t e;
      chk("busy_with_done", 32'(bus.busy), 32'd0);
      chk("pending_on_done", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.name, "_quotient"},  bus.quotient,     e.q);
        chk({e.name, "_remainder"}, bus.remainder,    e.r);
        chk({e.name, "_dz"},        32'(bus.dz),      32'(e.dz));
        chk({e.name, "_ovf"},       32'(bus.ovf),     32'(e.ovf));
        chk({e.name, "_latency"},   32'(cyc - e.e0),  32'(e.lat));
      end
    end
  end

  task automatic issue(input string nm, input logic off, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ovf,
                       input int lat, input bit push);
    @(negedge sys_clk);
    bus.start    = 1'b1;
    bus.offset   = off;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sb.push_back('{name: nm, q: q, r: r, dz: dz, ovf: ovf, e0: cyc + 1, lat: lat});
    @(negedge sys_clk);
    bus.start    = 1'b0;
    bus.offset   = ~off;
    bus.dividend = ~a;
    bus.divisor  = ~b;
  endtask

  task automatic wait_empty(input string nm, input int budget, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      if (bus.busy) busy_cnt++;
      @(negedge sys_clk);
    end
    chk({nm, "_timeout_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"},      32'(bus.busy),  32'd0);
    chk({nm, "_done"},      32'(bus.done),  32'd0);
    chk({nm, "_dz"},        32'(bus.dz),    32'd0);
    chk({nm, "_ovf"},       32'(bus.ovf),   32'd0);
    chk({nm, "_quotient"},  bus.quotient,   32'd0);
    chk({nm, "_remainder"}, bus.remainder,  32'd0);
  endtask

  initial begin
    int bc;
    int n;
    bus.start    = 1'b0;
    bus.offset   = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge sys_clk);
    chk_reset_vals("rst_held");
    resetl = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("rst_released");

    issue("d100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, 1'b1);
    wait_empty("d100_7", 100, bc);
    chk("d100_7_busy_cycles", 32'(bc), 32'd32);

    issue("off_1_2", 1'b1, 32'd1, 32'd2, 32'h0000_8000, 32'd0, 1'b0, 1'b0, 48, 1'b1);
    wait_empty("off_1_2", 100, bc);
    chk("off_1_2_busy_cycles", 32'(bc), 32'd48);

    issue("off_ovf", 1'b1, 32'h0001_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 48, 1'b1);
    wait_empty("off_ovf", 100, bc);

    issue("div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 0, 1'b1);
    wait_empty("div0", 20, bc);
    chk("div0_busy_cycles", 32'(bc), 32'd0);

    issue("max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32, 1'b1);
    wait_empty("max_1", 100, bc);

    issue("d5_max", 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 1'b0, 32, 1'b1);
    repeat (5) @(negedge sys_clk);
    chk("hold_quotient_in_run", bus.quotient, 32'hFFFF_FFFF);
    wait_empty("d5_max", 100, bc);

    // Start inside RUN is ignored, then start held through DONE restarts.
    issue("ign_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, 1'b1);
    repeat (8) @(negedge sys_clk);
    issue("ignored", 1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge sys_clk);
    bus.start    = 1'b1;
    bus.offset   = 1'b0;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b2b_first_done_seen", 32'(bus.done), 32'd1);
    sb.push_back('{name: "b2b_second", q: 32'd10, r: 32'd0, dz: 1'b0, ovf: 1'b0, e0: cyc + 1, lat: 32});
    @(negedge sys_clk);
    bus.start = 1'b0;
    wait_empty("b2b", 100, bc);

    // Reset mid-RUN aborts with no done pulse.
    issue("abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, 1'b0);
    repeat (14) @(negedge sys_clk);
    resetl = 1'b0;
    #1;
    chk_reset_vals("abort_rst");
    repeat (2) @(negedge sys_clk);
    resetl = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk_reset_vals("abort_after");

    issue("post_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 32, 1'b1);
    wait_empty("post_rst", 100, bc);
    chk("post_rst_busy_cycles", 32'(bc), 32'd32);

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
